// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Measures the period and high time of a slow square wave that is
//   asynchronous to clk_i. Both are counted in clk_i cycles. Each completed
//   rise-to-rise measurement is published with a one-cycle valid strobe.
//   Loss of signal is flagged after TIMEOUT cycles without a rising edge.
//
// Parameters
//   CNT_W       width of the counter and the measurement outputs
//   TIMEOUT     clk_i cycles without a rise before signal loss (<= 2^CNT_W-1)
//   SYNC_STAGES synchronizer depth on sig_i (>= 2)
//
// Ports
//   clk_i     system clock
//   rst_i     asynchronous reset, active-high
//   sig_i     measured signal, asynchronous to clk_i
//   period_o  last measured period (rise to rise), clk_i cycles
//   high_o    last measured high time (rise to fall), clk_i cycles
//   valid_o   one-cycle pulse when period_o/high_o update
//   timeout_o level, signal lost
//   locked_o  level, at least one valid measurement since reset or timeout
module clk_period_meter #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 1048576,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sig_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             timeout_o,
    output logic             locked_o
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hcap_q, hcap_d;
    logic                   flag_q, flag_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic                   locked_q, locked_d;

    logic             sig_s;
    logic             rise;
    logic             fall;
    logic             timeout_hit;
    logic [CNT_W-1:0] cnt_plus1;
    logic [CNT_W-1:0] cnt_inc;

    // Synchronizer and edge detection
    assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
    assign sig_s  = sync_q[SYNC_STAGES-1];
    assign prev_d = sig_s;
    assign rise   = sig_s & ~prev_q;
    assign fall   = ~sig_s & prev_q;

    assign cnt_plus1 = cnt_q + ONE;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_plus1;

    // A rise on the last counted cycle completes a measurement instead
    assign timeout_hit = (state_q == MEASURE) && (cnt_q == TO_LAST) && !rise;

    // State register and datapath flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            hcap_q    <= '0;
            flag_q    <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            hcap_q    <= hcap_d;
            flag_q    <= flag_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            locked_q  <= locked_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (rise)        state_d = MEASURE;
            MEASURE: if (timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        cnt_d     = cnt_q;
        hcap_d    = hcap_q;
        flag_d    = flag_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        locked_d  = locked_q;
        unique case (state_q)
            IDLE: begin
                // First rise only arms the measurement
                cnt_d = '0;
                if (rise) begin
                    flag_d = 1'b0;
                end
            end
            MEASURE: begin
                cnt_d = cnt_inc;
                if (rise) begin
                    period_d  = cnt_plus1;
                    high_d    = flag_q ? hcap_q : cnt_plus1;
                    valid_d   = 1'b1;
                    locked_d  = 1'b1;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    flag_d    = 1'b0;
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    cnt_d     = '0;
                end else if (fall) begin
                    hcap_d = cnt_plus1;
                    flag_d = 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign period_o  = period_q;
    assign high_o    = high_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;
    assign locked_o  = locked_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: two instances share clk/rst/sig. Instance 0 uses
// the default parameters; instance 1 uses TIMEOUT=64 and a 3-stage
// synchronizer. A timestamp reference model predicts each measurement or
// timeout event and the cycle it becomes visible; a monitor consumes them.
module tb_clk_period_meter;

    localparam int  T0 = 1048576;
    localparam int  S0 = 2;
    localparam int  T1 = 64;
    localparam int  S1 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig = 1'b0;

    logic [31:0] period0, high0, period1, high1;
    logic        valid0, timeout0, locked0, valid1, timeout1, locked1;

    always #5 clk = ~clk;

    clk_period_meter dut0 (
        .clk_i(clk), .rst_i(rst), .sig_i(sig),
        .period_o(period0), .high_o(high0), .valid_o(valid0),
        .timeout_o(timeout0), .locked_o(locked0)
    );

    clk_period_meter #(.CNT_W(32), .TIMEOUT(T1), .SYNC_STAGES(S1)) dut1 (
        .clk_i(clk), .rst_i(rst), .sig_i(sig),
        .period_o(period1), .high_o(high1), .valid_o(valid1),
        .timeout_o(timeout1), .locked_o(locked1)
    );

    typedef struct {
        int     kind;     // 0 = measurement, 1 = timeout raised
        longint cyc;      // cycle count at which it must be visible
        longint period;
        longint high;
    } ev_t;

    ev_t    q0[$];
    ev_t    q1[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    // ---------------- reference model (sample timestamps) ----------------
    bit     prev_v;
    bit     armed     [2];
    longint last_rise [2];
    bit     fall_seen [2];
    longint fall_at   [2];
    bit     tflag     [2];
    longint last_p    [2];
    longint last_h    [2];

    function automatic longint tmo_of(int k);
        return (k == 0) ? longint'(T0) : longint'(T1);
    endfunction

    function automatic longint stg_of(int k);
        return (k == 0) ? longint'(S0) : longint'(S1);
    endfunction

    task automatic push(int k, ev_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ev_t qfront(int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(int k, output ev_t e);
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    // n = cyc is the index of the clock edge that sampled v
    task automatic model_step(int k, bit v);
        bit  r;
        bit  f;
        ev_t e;
        r = v && !prev_v;
        f = !v && prev_v;
        if (r) begin
            if (armed[k]) begin
                e.kind   = 0;
                e.cyc    = cyc + stg_of(k);
                e.period = cyc - last_rise[k];
                e.high   = fall_seen[k] ? (fall_at[k] - last_rise[k]) : e.period;
                push(k, e);
                last_p[k] = e.period;
                last_h[k] = e.high;
                tflag[k]  = 1'b0;
            end
            armed[k]     = 1'b1;
            last_rise[k] = cyc;
            fall_seen[k] = 1'b0;
        end else if (armed[k]) begin
            if (cyc == last_rise[k] + tmo_of(k)) begin
                if (!tflag[k]) begin
                    e.kind   = 1;
                    e.cyc    = cyc + stg_of(k);
                    e.period = last_p[k];
                    e.high   = last_h[k];
                    push(k, e);
                end
                tflag[k] = 1'b1;
                armed[k] = 1'b0;
            end else if (f) begin
                fall_seen[k] = 1'b1;
                fall_at[k]   = cyc;
            end
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            prev_v = 1'b0;
            for (int k = 0; k < 2; k++) begin
                armed[k]     = 1'b0;
                fall_seen[k] = 1'b0;
                tflag[k]     = 1'b0;
                last_p[k]    = 0;
                last_h[k]    = 0;
                last_rise[k] = 0;
                fall_at[k]   = 0;
            end
            q0.delete();
            q1.delete();
        end else begin
            model_step(0, sig);
            model_step(1, sig);
            prev_v = sig;
        end
    end

    // ---------------- checking ----------------
    task automatic check(string name, int k, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc=%0d: got %0d, expected %0d", name, k, cyc, act, exp);
        end
    endtask

    bit tprev [2];
    bit lvl_t [2];
    bit lvl_l [2];

    task automatic monitor(int k, logic v, logic t, logic l, logic [31:0] p, logic [31:0] h);
        ev_t e;
        while (qsize(k) > 0 && qfront(k).cyc < cyc) begin
            qpop(k, e);
            checks++;
            errors++;
            $display("FAIL missed_event inst%0d cyc=%0d: got nothing, expected kind %0d at cyc %0d",
                     k, cyc, e.kind, e.cyc);
            lvl_t[k] = (e.kind == 1);
            lvl_l[k] = (e.kind == 0);
        end
        if (qsize(k) > 0 && qfront(k).cyc == cyc) begin
            qpop(k, e);
            if (e.kind == 0) begin
                check("valid_o", k, longint'(v), 1);
                check("period_o", k, longint'(p), e.period);
                check("high_o", k, longint'(h), e.high);
                lvl_t[k] = 1'b0;
                lvl_l[k] = 1'b1;
            end else begin
                check("timeout_rise", k, longint'(t && !tprev[k]), 1);
                check("period_hold", k, longint'(p), e.period);
                check("high_hold", k, longint'(h), e.high);
                lvl_t[k] = 1'b1;
                lvl_l[k] = 1'b0;
            end
        end else begin
            check("valid_idle", k, longint'(v), 0);
        end
        check("timeout_o", k, longint'(t), longint'(lvl_t[k]));
        check("locked_o", k, longint'(l), longint'(lvl_l[k]));
        tprev[k] = t;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                tprev[k] = 1'b0;
                lvl_t[k] = 1'b0;
                lvl_l[k] = 1'b0;
            end
        end else begin
            monitor(0, valid0, timeout0, locked0, period0, high0);
            monitor(1, valid1, timeout1, locked1, period1, high1);
        end
    end

    task automatic check_zero(string tag);
        check({tag, "_period"}, 0, longint'(period0), 0);
        check({tag, "_high"}, 0, longint'(high0), 0);
        check({tag, "_valid"}, 0, longint'(valid0), 0);
        check({tag, "_timeout"}, 0, longint'(timeout0), 0);
        check({tag, "_locked"}, 0, longint'(locked0), 0);
        check({tag, "_period"}, 1, longint'(period1), 0);
        check({tag, "_high"}, 1, longint'(high1), 0);
        check({tag, "_valid"}, 1, longint'(valid1), 0);
        check({tag, "_timeout"}, 1, longint'(timeout1), 0);
        check({tag, "_locked"}, 1, longint'(locked1), 0);
    endtask

    // ---------------- stimulus ----------------
    // Called just after a falling edge; sig changes only there
    task automatic drive(int hi, int lo, int reps);
        for (int r = 0; r < reps; r++) begin
            sig = 1'b1;
            repeat (hi) @(negedge clk);
            sig = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    initial begin
        ev_t e;
        repeat (3) @(negedge clk);
        check_zero("reset");
        #1 rst = 1'b0;

        drive(5, 5, 6);                 // steady 5/5
        drive(3, 7, 4);                 // duty change
        drive(1, 1, 6);                 // fastest input
        drive(202, 202, 3);             // divided clock; instance 1 times out
        drive(5, 5, 4);
        sig = 1'b0;
        repeat (200) @(negedge clk);    // signal lost
        drive(5, 5, 4);                 // recovery
        drive(31, 32, 2);               // period 63
        drive(32, 32, 3);               // period 64: rise meets the last count
        drive(32, 33, 2);               // period 65: timeout then re-arm
        drive(5, 5, 3);

        // asynchronous reset mid-cycle while sig keeps toggling
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_zero("midreset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sig = ~sig;
        end
        @(negedge clk);
        #1 rst = 1'b0;
        drive(5, 5, 4);

        for (int i = 0; i < 40; i++) begin
            drive(int'($urandom_range(1, 80)), int'($urandom_range(1, 80)), 1);
        end

        sig = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            while (qsize(k) > 0 && qfront(k).cyc <= cyc) begin
                qpop(k, e);
                checks++;
                errors++;
                $display("FAIL missed_event inst%0d at end: got nothing, expected kind %0d at cyc %0d",
                         k, e.kind, e.cyc);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
